// File: rtl/jvm_arm_translator.sv
// Streaming JVM bytecode to ARM translator: operand bytes become MOVW/MOVT/push,
// followed by a per-opcode template fetched from a runtime-loaded memory.
//
// state      | meaning
// FETCH_OP   | waiting for an opcode or wide prefix byte
// LOOKUP     | read opcode table, size the operand fetch
// FETCH_OPND | shifting operand bytes into the accumulator
// EMIT_MOVW  | presenting MOVW of imm[15:0]
// EMIT_MOVT  | presenting MOVT of imm[31:16]
// EMIT_PUSH  | presenting push of the immediate register
// EMIT_TPL   | presenting template words
module jvm_arm_translator #(
  parameter int         TPL_AW      = 8,
  parameter logic [7:0] WIDE_OPCODE = 8'hC4,
  parameter int         IMM_REG     = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [TPL_AW-1:0] cfg_addr,
  input  logic [31:0]       cfg_wdata,
  output logic              busy,
  output logic              err,
  output logic [15:0]       insn_count
);

  localparam int ENT_W = 2*TPL_AW + 3;
  localparam logic [3:0] IMM_R = 4'(IMM_REG);
  localparam logic [TPL_AW-1:0] TPL_ONE = 1;
  localparam logic [31:0] PUSH_WORD = {16'hE52D, IMM_R, 12'h004};

  typedef enum logic [2:0] {
    FETCH_OP, LOOKUP, FETCH_OPND, EMIT_MOVW, EMIT_MOVT, EMIT_PUSH, EMIT_TPL
  } state_t;

  state_t state;
  logic [ENT_W-1:0]  tbl_mem [256];
  logic [31:0]       tpl_mem [2**TPL_AW];
  logic              wide, is_signed;
  logic [7:0]        opcode;
  logic [31:0]       acc, imm;
  logic [2:0]        nbytes, rem;
  logic [TPL_AW-1:0] tpl_start, tpl_len, tpl_addr, tpl_rem;

  logic [ENT_W-1:0]  ent;
  logic [TPL_AW-1:0] ent_start, ent_len;
  logic [1:0]        ent_n, n_eff;
  logic              ent_signed;
  logic [2:0]        lk_nbytes;
  logic [31:0]       acc_next, imm_next;
  logic              in_fire, out_fire;
  logic              unused_cfg;

  assign in_ready = (state == FETCH_OP) || (state == FETCH_OPND);
  assign busy     = (state != FETCH_OP);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign ent        = tbl_mem[opcode];
  assign ent_start  = ent[TPL_AW-1:0];
  assign ent_len    = ent[2*TPL_AW-1:TPL_AW];
  assign ent_n      = ent[2*TPL_AW+1:2*TPL_AW];
  assign ent_signed = ent[2*TPL_AW+2];
  assign n_eff      = (ent_n == 2'd3) ? 2'd2 : ent_n;
  assign lk_nbytes  = wide ? {n_eff, 1'b0} : {1'b0, n_eff};
  assign acc_next   = {acc[23:0], in_byte};
  assign unused_cfg = ^cfg_wdata[31:ENT_W];

  always_comb begin
    imm_next = acc_next;
    case (nbytes)
      3'd1: imm_next = {{24{is_signed & acc_next[7]}},  acc_next[7:0]};
      3'd2: imm_next = {{16{is_signed & acc_next[15]}}, acc_next[15:0]};
      3'd3: imm_next = {{8{is_signed & acc_next[23]}},  acc_next[23:0]};
      default: imm_next = acc_next;
    endcase
  end

  // Config writes are locked out mid-bytecode so the combinational reads stay coherent.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      if (cfg_sel) tpl_mem[cfg_addr] <= cfg_wdata;
      else         tbl_mem[8'(cfg_addr)] <= cfg_wdata[ENT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FETCH_OP;
      out_valid  <= 1'b0;
      out_word   <= '0;
      err        <= 1'b0;
      insn_count <= '0;
      wide       <= 1'b0;
      opcode     <= '0;
      acc        <= '0;
      imm        <= '0;
      nbytes     <= '0;
      rem        <= '0;
      is_signed  <= 1'b0;
      tpl_start  <= '0;
      tpl_len    <= '0;
      tpl_addr   <= '0;
      tpl_rem    <= '0;
    end else begin
      case (state)
        FETCH_OP: if (in_fire) begin
          if (in_byte == WIDE_OPCODE) begin
            if (wide) begin
              err  <= 1'b1;
              wide <= 1'b0;
            end else begin
              wide <= 1'b1;
            end
          end else begin
            opcode <= in_byte;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          is_signed <= ent_signed;
          tpl_start <= ent_start;
          tpl_len   <= ent_len;
          nbytes    <= lk_nbytes;
          rem       <= lk_nbytes;
          acc       <= '0;
          if (lk_nbytes != 3'd0) begin
            state <= FETCH_OPND;
          end else if (ent_len != '0) begin
            out_valid <= 1'b1;
            out_word  <= tpl_mem[ent_start];
            tpl_addr  <= ent_start + TPL_ONE;
            tpl_rem   <= ent_len - TPL_ONE;
            state     <= EMIT_TPL;
          end else begin
            insn_count <= insn_count + 16'd1;
            wide       <= 1'b0;
            state      <= FETCH_OP;
          end
        end
        FETCH_OPND: if (in_fire) begin
          acc <= acc_next;
          rem <= rem - 3'd1;
          if (rem == 3'd1) begin
            imm       <= imm_next;
            out_valid <= 1'b1;
            out_word  <= {12'hE30, imm_next[15:12], IMM_R, imm_next[11:0]};
            state     <= EMIT_MOVW;
          end
        end
        EMIT_MOVW: if (out_fire) begin
          if (imm[31:16] != 16'd0) begin
            out_word <= {12'hE34, imm[31:28], IMM_R, imm[27:16]};
            state    <= EMIT_MOVT;
          end else begin
            out_word <= PUSH_WORD;
            state    <= EMIT_PUSH;
          end
        end
        EMIT_MOVT: if (out_fire) begin
          out_word <= PUSH_WORD;
          state    <= EMIT_PUSH;
        end
        EMIT_PUSH: if (out_fire) begin
          if (tpl_len != '0) begin
            out_word <= tpl_mem[tpl_start];
            tpl_addr <= tpl_start + TPL_ONE;
            tpl_rem  <= tpl_len - TPL_ONE;
            state    <= EMIT_TPL;
          end else begin
            out_valid  <= 1'b0;
            insn_count <= insn_count + 16'd1;
            wide       <= 1'b0;
            state      <= FETCH_OP;
          end
        end
        EMIT_TPL: if (out_fire) begin
          if (tpl_rem == '0) begin
            out_valid  <= 1'b0;
            insn_count <= insn_count + 16'd1;
            wide       <= 1'b0;
            state      <= FETCH_OP;
          end else begin
            out_word <= tpl_mem[tpl_addr];
            tpl_addr <= tpl_addr + TPL_ONE;
            tpl_rem  <= tpl_rem - TPL_ONE;
          end
        end
        default: state <= FETCH_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_jvm_arm_translator.sv
// Directed bench for jvm_arm_translator: inputs driven on the falling edge,
// outputs sampled on the falling edge, expected words computed by hand.
module tb_jvm_arm_translator;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready;
  logic        cfg_we, cfg_sel, busy, err;
  logic [7:0]  in_byte, cfg_addr;
  logic [31:0] out_word, cfg_wdata;
  logic [15:0] insn_count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jvm_arm_translator #(.TPL_AW(8), .WIDE_OPCODE(8'hC4), .IMM_REG(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_byte(in_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .busy(busy), .err(err),
    .insn_count(insn_count)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input logic sel, input logic [7:0] addr, input logic [31:0] data);
    cfg_sel = sel; cfg_addr = addr; cfg_wdata = data; cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_byte = b; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_byte_timeout byte=%h in_ready=%b required=1", b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic get_word(output logic [31:0] w);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL get_word_timeout out_valid=%b required=1", out_valid);
      w = 'x;
    end else begin
      w = out_word;
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks += 6;
    if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_word !== 32'h0)   begin errors++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
    if (err !== 1'b0)         begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    if (insn_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", insn_count); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic load_config;
    cfg_write(1'b0, 8'h10, 32'h0005_0000);  // n=1 signed, L=0
    cfg_write(1'b0, 8'h15, 32'h0001_0104);  // n=1 unsigned, L=1, start=4
    cfg_write(1'b0, 8'h11, 32'h0002_0000);  // n=2 unsigned, L=0
    cfg_write(1'b0, 8'h60, 32'h0000_03FE);  // n=0, L=3, start=254
    cfg_write(1'b0, 8'h00, 32'h0000_0000);  // nothing emitted
    cfg_write(1'b1, 8'd4,   32'hE12F_FF1E);
    cfg_write(1'b1, 8'd254, 32'hA000_0001);
    cfg_write(1'b1, 8'd255, 32'hB000_0002);
    cfg_write(1'b1, 8'd0,   32'hC000_0003);
  endtask

  task automatic test_bipush;
    logic [31:0] w [3];
    send_byte(8'h10); send_byte(8'hFF);
    for (int i = 0; i < 3; i++) get_word(w[i]);
    checks += 5;
    if (w[0] !== 32'hE30F0FFF) begin errors++; $display("FAIL bipush_movw got=%h exp=E30F0FFF", w[0]); end
    if (w[1] !== 32'hE34F0FFF) begin errors++; $display("FAIL bipush_movt got=%h exp=E34F0FFF", w[1]); end
    if (w[2] !== 32'hE52D0004) begin errors++; $display("FAIL bipush_push got=%h exp=E52D0004", w[2]); end
    if (insn_count !== 16'd1)  begin errors++; $display("FAIL bipush_count got=%0d exp=1", insn_count); end
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bipush_idle busy=%b in_ready=%b exp busy=0 in_ready=1", busy, in_ready);
    end
  endtask

  task automatic test_wide_iload;
    logic [31:0] w [3];
    send_byte(8'hC4); send_byte(8'h15); send_byte(8'h01); send_byte(8'h02);
    for (int i = 0; i < 3; i++) get_word(w[i]);
    checks += 5;
    if (w[0] !== 32'hE3000102) begin errors++; $display("FAIL wide_movw got=%h exp=E3000102", w[0]); end
    if (w[1] !== 32'hE52D0004) begin errors++; $display("FAIL wide_push got=%h exp=E52D0004", w[1]); end
    if (w[2] !== 32'hE12FFF1E) begin errors++; $display("FAIL wide_tpl got=%h exp=E12FFF1E", w[2]); end
    if (insn_count !== 16'd2)  begin errors++; $display("FAIL wide_count got=%0d exp=2", insn_count); end
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL wide_extra_word out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_wide_movt;
    logic [31:0] w [3];
    send_byte(8'hC4); send_byte(8'h11);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    for (int i = 0; i < 3; i++) get_word(w[i]);
    checks += 4;
    if (w[0] !== 32'hE3050678) begin errors++; $display("FAIL wide2_movw got=%h exp=E3050678", w[0]); end
    if (w[1] !== 32'hE3410234) begin errors++; $display("FAIL wide2_movt got=%h exp=E3410234", w[1]); end
    if (w[2] !== 32'hE52D0004) begin errors++; $display("FAIL wide2_push got=%h exp=E52D0004", w[2]); end
    if (insn_count !== 16'd3)  begin errors++; $display("FAIL wide2_count got=%0d exp=3", insn_count); end
  endtask

  task automatic test_tpl_wrap;
    logic [31:0] exp_w [3] = '{32'hA0000001, 32'hB0000002, 32'hC0000003};
    in_byte = 8'h60; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL wrap_lookup out_valid=%b busy=%b exp 0 1", out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_word !== exp_w[i]) begin
        errors++; $display("FAIL wrap_word%0d valid=%b got=%h exp=%h", i, out_valid, out_word, exp_w[i]);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || insn_count !== 16'd4) begin
      errors++; $display("FAIL wrap_done valid=%b count=%0d exp 0 4", out_valid, insn_count);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] w;
    send_byte(8'h15); send_byte(8'h07);
    get_word(w);
    checks++;
    if (w !== 32'hE3000007) begin errors++; $display("FAIL bp_movw got=%h exp=E3000007", w); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_word !== 32'hE52D0004 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d valid=%b word=%h in_ready=%b busy=%b exp 1 E52D0004 0 1",
                 i, out_valid, out_word, in_ready, busy);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 32'hE12FFF1E) begin
      errors++; $display("FAIL bp_single valid=%b word=%h exp 1 E12FFF1E", out_valid, out_word);
    end
    get_word(w);
    checks++;
    if (w !== 32'hE12FFF1E || insn_count !== 16'd5) begin
      errors++; $display("FAIL bp_tpl word=%h count=%0d exp E12FFF1E 5", w, insn_count);
    end
  endtask

  task automatic test_no_emit;
    send_byte(8'h00);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL noemit_lookup busy=%b in_ready=%b exp 1 0", busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (insn_count !== 16'd6 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL noemit_done count=%0d valid=%b busy=%b exp 6 0 0", insn_count, out_valid, busy);
    end
  endtask

  task automatic test_double_wide;
    logic [31:0] w [2];
    send_byte(8'hC4); send_byte(8'hC4);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL dwide_err got=%b exp=1", err); end
    send_byte(8'h10); send_byte(8'h05);
    for (int i = 0; i < 2; i++) get_word(w[i]);
    checks += 4;
    if (w[0] !== 32'hE3000005) begin errors++; $display("FAIL dwide_movw got=%h exp=E3000005", w[0]); end
    if (w[1] !== 32'hE52D0004) begin errors++; $display("FAIL dwide_push got=%h exp=E52D0004", w[1]); end
    if (err !== 1'b1)          begin errors++; $display("FAIL dwide_sticky got=%b exp=1", err); end
    if (insn_count !== 16'd7)  begin errors++; $display("FAIL dwide_count got=%0d exp=7", insn_count); end
  endtask

  task automatic test_reset_midop;
    logic [31:0] w [2];
    send_byte(8'h10); send_byte(8'h05);
    get_word(w[0]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state valid=%b in_ready=%b busy=%b exp 0 1 0", out_valid, in_ready, busy);
    end
    if (insn_count !== 16'd0 || err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_regs count=%0d err=%b exp 0 0", insn_count, err);
    end
    send_byte(8'h10); send_byte(8'h05);
    for (int i = 0; i < 2; i++) get_word(w[i]);
    checks += 3;
    if (w[0] !== 32'hE3000005) begin errors++; $display("FAIL rst_retain_movw got=%h exp=E3000005", w[0]); end
    if (w[1] !== 32'hE52D0004) begin errors++; $display("FAIL rst_retain_push got=%h exp=E52D0004", w[1]); end
    if (insn_count !== 16'd1)  begin errors++; $display("FAIL rst_retain_count got=%0d exp=1", insn_count); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = '0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset;
    load_config;
    test_bipush;
    test_wide_iload;
    test_wide_movt;
    test_tpl_wrap;
    test_backpressure;
    test_no_emit;
    test_double_wide;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
